// File: rtl/func_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit vector into an external
// combinational function, samples its output after SETTLE cycles and scores it.
module func_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic                 fail_valid,
  output logic [1:0]           state_dbg
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // Handshake: start is a level request, accepted on any edge where busy is
  // low (IDLE or DONE); while busy it is ignored. done is sticky until rst or
  // the next accepted start.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [NV-1:0]     exp_reg, exp_n;
  logic [N_IN-1:0]   vec_n;
  logic              busy_n, done_n, fv_n;
  logic [NV-1:0]     tt_n;
  logic [N_IN:0]     mc_n;
  logic [N_IN-1:0]   ff_n;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      exp_reg      <= '0;
      vec_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tt_out       <= '0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      fail_valid   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      exp_reg      <= exp_n;
      vec_out      <= vec_n;
      busy         <= busy_n;
      done         <= done_n;
      tt_out       <= tt_n;
      mismatch_cnt <= mc_n;
      first_fail   <= ff_n;
      fail_valid   <= fv_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    exp_n   = exp_reg;
    vec_n   = vec_out;
    busy_n  = busy;
    done_n  = done;
    tt_n    = tt_out;
    mc_n    = mismatch_cnt;
    ff_n    = first_fail;
    fv_n    = fail_valid;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          exp_n   = expected;
          tt_n    = '0;
          mc_n    = '0;
          ff_n    = '0;
          fv_n    = 1'b0;
          done_n  = 1'b0;
          busy_n  = 1'b1;
          vec_n   = '0;
          cnt_n   = CW'(SETTLE - 1);
          state_n = RUN;
        end
      end
      RUN: begin
        // cnt counts the remaining hold cycles; zero means this edge samples.
        if (cnt == '0) begin
          tt_n[vec_out] = f_in;
          if (f_in != exp_reg[vec_out]) begin
            mc_n = mismatch_cnt + (N_IN+1)'(1);
            if (!fail_valid) begin
              ff_n = vec_out;
              fv_n = 1'b1;
            end
          end
          if (vec_out != N_IN'(NV - 1)) begin
            vec_n = vec_out + N_IN'(1);
            cnt_n = CW'(SETTLE - 1);
          end else begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            vec_n   = '0;
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_func_sweep_checker.sv
// Bench for func_sweep_checker: two instances (SETTLE=1 and SETTLE=3) checked
// every cycle against a timeline model, plus hand-computed literal results.
module tb_func_sweep_checker;

  localparam int N  = 4;
  localparam int NV = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_v   [2];
  logic            start_v [2];
  logic [NV-1:0]   exp_v   [2];
  logic            fmode   [2];
  logic            f_v     [2];
  logic [N-1:0]    vec_o   [2];
  logic            busy_o  [2];
  logic            done_o  [2];
  logic [NV-1:0]   tt_o    [2];
  logic [N:0]      mc_o    [2];
  logic [N-1:0]    ff_o    [2];
  logic            fv_o    [2];
  logic [1:0]      st_o    [2];

  // External function under test: f = vec[2] or constant 0.
  assign f_v[0] = fmode[0] ? vec_o[0][2] : 1'b0;
  assign f_v[1] = fmode[1] ? vec_o[1][2] : 1'b0;

  func_sweep_checker #(.N_IN(N), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .expected(exp_v[0]),
    .f_in(f_v[0]), .vec_out(vec_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .tt_out(tt_o[0]), .mismatch_cnt(mc_o[0]), .first_fail(ff_o[0]),
    .fail_valid(fv_o[0]), .state_dbg(st_o[0])
  );

  func_sweep_checker #(.N_IN(N), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .expected(exp_v[1]),
    .f_in(f_v[1]), .vec_out(vec_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .tt_out(tt_o[1]), .mismatch_cnt(mc_o[1]), .first_fail(ff_o[1]),
    .fail_valid(fv_o[1]), .state_dbg(st_o[1])
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Model: a sweep started at edge e0 samples vector k at edge e0+S*(k+1),
  // and in between the applied vector is simply elapsed/S.
  bit          m_busy [2];
  bit          m_done [2];
  int          m_e0   [2];
  logic [15:0] m_exp  [2];
  logic [15:0] m_tt   [2];
  int          m_mc   [2];
  int          m_ff   [2];
  bit          m_fv   [2];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int s, el, k;
      bit fk;
      s = (d == 0) ? 1 : 3;
      if (rst_v[d]) begin
        m_busy[d] = 0; m_done[d] = 0; m_e0[d] = 0; m_exp[d] = '0;
        m_tt[d] = '0; m_mc[d] = 0; m_ff[d] = 0; m_fv[d] = 0;
      end else if (!m_busy[d]) begin
        if (start_v[d]) begin
          m_busy[d] = 1; m_done[d] = 0; m_e0[d] = cyc; m_exp[d] = exp_v[d];
          m_tt[d] = '0; m_mc[d] = 0; m_ff[d] = 0; m_fv[d] = 0;
        end
      end else begin
        el = cyc - m_e0[d];
        if (el % s == 0) begin
          k  = el / s - 1;
          fk = fmode[d] ? ((k >> 2) & 1) : 1'b0;
          m_tt[d][k] = fk;
          if (fk != m_exp[d][k]) begin
            m_mc[d]++;
            if (!m_fv[d]) begin
              m_ff[d] = k;
              m_fv[d] = 1;
            end
          end
          if (k == NV - 1) begin
            m_busy[d] = 0;
            m_done[d] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        int s, mv, mst;
        s   = (d == 0) ? 1 : 3;
        mv  = m_busy[d] ? (cyc - m_e0[d]) / s : 0;
        mst = m_busy[d] ? 1 : (m_done[d] ? 2 : 0);
        chk($sformatf("vec_out[%0d]", d), 32'(vec_o[d]), 32'(mv));
        chk($sformatf("busy[%0d]", d), 32'(busy_o[d]), 32'(m_busy[d]));
        chk($sformatf("done[%0d]", d), 32'(done_o[d]), 32'(m_done[d]));
        chk($sformatf("tt_out[%0d]", d), 32'(tt_o[d]), 32'(m_tt[d]));
        chk($sformatf("mismatch_cnt[%0d]", d), 32'(mc_o[d]), 32'(m_mc[d]));
        chk($sformatf("first_fail[%0d]", d), 32'(ff_o[d]), 32'(m_ff[d]));
        chk($sformatf("fail_valid[%0d]", d), 32'(fv_o[d]), 32'(m_fv[d]));
        chk($sformatf("state_dbg[%0d]", d), 32'(st_o[d]), 32'(mst));
      end
    end
  end

  // Start pulse: on return we sit at the negedge right after edge E0.
  task automatic pulse_start(input int d, input logic [15:0] e, output int e0);
    @(negedge clk);
    start_v[d] = 1'b1;
    exp_v[d]   = e;
    @(negedge clk);
    start_v[d] = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int d, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (done_o[d] === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) chk($sformatf("done_timeout[%0d]", d), 32'(0), 32'(1));
  endtask

  task automatic wait_vec(input int d, input logic [3:0] v);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (vec_o[d] === v) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk($sformatf("vec_wait[%0d]", d), 32'(0), 32'(1));
  endtask

  task automatic chk_results(input int d, input logic [15:0] tt, input int mc,
                             input int ff, input bit fv);
    chk("lit_tt", 32'(tt_o[d]), 32'(tt));
    chk("lit_mc", 32'(mc_o[d]), 32'(mc));
    chk("lit_ff", 32'(ff_o[d]), 32'(ff));
    chk("lit_fv", 32'(fv_o[d]), 32'(fv));
    chk("lit_vec_end", 32'(vec_o[d]), 32'(0));
  endtask

  initial begin
    int e0, at;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; start_v[d] = 1'b0; exp_v[d] = '0; fmode[d] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    chk("reset_busy", 32'(busy_o[0]), 32'(0));
    chk("reset_tt", 32'(tt_o[1]), 32'(0));
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // f = vec[2], expected matches: clean pass, done 16 edges after E0.
    pulse_start(0, 16'hF0F0, e0);
    chk("busy_after_start", 32'(busy_o[0]), 32'(1));
    wait_done(0, at);
    chk("done_latency_s1", 32'(at - e0), 32'(16));
    chk_results(0, 16'hF0F0, 0, 0, 1'b0);

    // Expected omits the top nibble: minterms 12..15 fail.
    pulse_start(0, 16'h00F0, e0);
    wait_done(0, at);
    chk_results(0, 16'hF0F0, 4, 12, 1'b1);

    // f tied low against all-ones: every minterm fails, count reaches 16.
    fmode[0] = 1'b0;
    pulse_start(0, 16'hFFFF, e0);
    wait_done(0, at);
    chk_results(0, 16'h0000, 16, 0, 1'b1);
    fmode[0] = 1'b1;

    // SETTLE=3 instance: same function, 48-edge sweep.
    pulse_start(1, 16'hF0F0, e0);
    wait_done(1, at);
    chk("done_latency_s3", 32'(at - e0), 32'(48));
    chk_results(1, 16'hF0F0, 0, 0, 1'b0);

    // Reset mid-sweep at vector 7, then a full clean sweep.
    pulse_start(0, 16'h00F0, e0);
    wait_vec(0, 4'd7);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("rst_busy", 32'(busy_o[0]), 32'(0));
    chk("rst_done", 32'(done_o[0]), 32'(0));
    chk("rst_vec", 32'(vec_o[0]), 32'(0));
    chk("rst_tt", 32'(tt_o[0]), 32'(0));
    chk("rst_mc", 32'(mc_o[0]), 32'(0));
    pulse_start(0, 16'hF0F0, e0);
    wait_done(0, at);
    chk_results(0, 16'hF0F0, 0, 0, 1'b0);

    // Start and expected change mid-run are ignored.
    pulse_start(0, 16'hF0F0, e0);
    wait_vec(0, 4'd5);
    start_v[0] = 1'b1;
    exp_v[0]   = 16'h0000;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, at);
    chk("midrun_latency", 32'(at - e0), 32'(16));
    chk_results(0, 16'hF0F0, 0, 0, 1'b0);

    // Start from DONE clears done on the next edge.
    pulse_start(0, 16'h00F0, e0);
    chk("restart_done_clr", 32'(done_o[0]), 32'(0));
    chk("restart_busy", 32'(busy_o[0]), 32'(1));
    wait_done(0, at);
    chk_results(0, 16'hF0F0, 4, 12, 1'b1);

    // Start held high: a new sweep begins the edge after done rises.
    @(negedge clk);
    exp_v[0]   = 16'hF0F0;
    start_v[0] = 1'b1;
    @(negedge clk);
    wait_done(0, at);
    @(negedge clk);
    chk("held_start_done_clr", 32'(done_o[0]), 32'(0));
    chk("held_start_busy", 32'(busy_o[0]), 32'(1));
    start_v[0] = 1'b0;
    wait_done(0, at);
    chk_results(0, 16'hF0F0, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
